// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V pipeline control slice.
//   - RV32 base opcodes used by the hazard unit's decoder
//   - PC select encoding driven onto hazard_ctrl.pc_sel
//   - per-stage destination metadata carried down the pipe
package riscv_ctrl_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    // Register index width used for the stored rd field.
    localparam int unsigned RV_REG_AW = 5;

    typedef enum logic [1:0] {
        PC_SEL_JAL   = 2'd0,
        PC_SEL_ALU   = 2'd1,
        PC_SEL_PLUS4 = 2'd2,
        PC_SEL_HOLD  = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic                 wr_en;
        logic                 is_load;
        logic                 is_jalr;
        logic                 is_branch;
    } stage_meta_t;

endpackage

// File: rtl/inst_fields_dec.sv
// Combinational field/class decoder for one 32-bit RV32 instruction.
// Ports:
//   inst      : instruction word
//   rd/rs1/rs2: register indices
//   rs1_used  : OP, OP-IMM, LOAD, STORE, BRANCH, JALR read rs1
//   rs2_used  : OP, STORE, BRANCH read rs2
//   wr_en     : instruction writes a non-x0 destination
//   is_load/is_jal/is_jalr/is_branch : class flags
module inst_fields_dec
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [31:0]       inst,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic              rs1_used,
    output logic              rs2_used,
    output logic              wr_en,
    output logic              is_load,
    output logic              is_jal,
    output logic              is_jalr,
    output logic              is_branch
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign unused_fields = ^{inst[31:25], inst[14:12]};

    always_comb begin
        opcode    = inst[6:0];
        rd        = inst[7 +: REG_AW];
        rs1       = inst[15 +: REG_AW];
        rs2       = inst[20 +: REG_AW];

        is_load   = (opcode == LOAD);
        is_jal    = (opcode == JAL);
        is_jalr   = (opcode == JALR);
        is_branch = (opcode == BRANCH);

        rs1_used  = (opcode == OP) || (opcode == OP_IMM) || (opcode == LOAD) ||
                    (opcode == STORE) || (opcode == BRANCH) || (opcode == JALR);
        rs2_used  = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);

        wr_en     = ((opcode == OP) || (opcode == OP_IMM) || (opcode == LOAD) ||
                     (opcode == LUI) || (opcode == AUIPC) || (opcode == JAL) ||
                     (opcode == JALR)) && (rd != '0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control and hazard unit.
// Tracks destination metadata for NUM_STAGES stages after FD (stage 1 = X,
// last = writeback) and produces PC select, forwarding selects, load-use and
// memory stalls, and redirect flushes of FLUSH_DEPTH fetched instructions.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   inst_fd     : instruction in FD;  fd_valid: FD holds a real instruction
//   br_taken_x  : branch outcome for the instruction in X
//   mem_ready   : 0 freezes the whole pipe
//   pc_sel      : 0=PC+imm, 1=ALU, 2=PC+4, 3=hold
//   is_j_or_b   : X holds a valid JALR or branch
//   fwd_a_sel/fwd_b_sel : 0=regfile, k=stage k result
//   stall       : hold PC and FD;  flush_fd: kill the FD instruction
module hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       inst_fd,
    input  logic                              fd_valid,
    input  logic                              br_taken_x,
    input  logic                              mem_ready,
    output logic [1:0]                        pc_sel,
    output logic                              is_j_or_b,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_a_sel,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_b_sel,
    output logic                              stall,
    output logic                              flush_fd
);

    localparam int unsigned FW = $clog2(NUM_STAGES + 1);
    localparam int unsigned KW = $clog2(FLUSH_DEPTH + 1);

    stage_meta_t       stg_q [1:NUM_STAGES];
    stage_meta_t       stg_d [1:NUM_STAGES];
    logic [KW-1:0]     kill_cnt_q;
    logic [KW-1:0]     kill_cnt_d;

    logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
    logic              dec_rs1_used, dec_rs2_used, dec_wr_en;
    logic              dec_is_load, dec_is_jal, dec_is_jalr, dec_is_branch;

    logic              redirect, killing, flush_c, fd_live, lu_stall;
    logic [FW-1:0]     sel_a, sel_b;
    logic              near_load_a, near_load_b;
    pc_sel_e           pc_sel_c;
    logic              stall_c;
    stage_meta_t       fd_meta;

    inst_fields_dec #(.REG_AW(REG_AW)) u_dec_fd (
        .inst      (inst_fd),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rs1_used  (dec_rs1_used),
        .rs2_used  (dec_rs2_used),
        .wr_en     (dec_wr_en),
        .is_load   (dec_is_load),
        .is_jal    (dec_is_jal),
        .is_jalr   (dec_is_jalr),
        .is_branch (dec_is_branch)
    );

    // Flush is resolved before load-use so a killed FD instruction never stalls.
    always_comb begin
        redirect = stg_q[1].valid &
                   (stg_q[1].is_jalr | (stg_q[1].is_branch & br_taken_x));
        killing  = (kill_cnt_q != '0);
        flush_c  = mem_ready & (redirect | killing);
        fd_live  = fd_valid & ~flush_c;
    end

    // Scan from the youngest stage so the nearest producer wins.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        near_load_a = 1'b0;
        near_load_b = 1'b0;
        for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
            if (sel_a == '0 && dec_rs1_used && stg_q[k].valid &&
                stg_q[k].wr_en && stg_q[k].rd == dec_rs1) begin
                sel_a       = FW'(k);
                near_load_a = stg_q[k].is_load && (k <= LOAD_LAT);
            end
            if (sel_b == '0 && dec_rs2_used && stg_q[k].valid &&
                stg_q[k].wr_en && stg_q[k].rd == dec_rs2) begin
                sel_b       = FW'(k);
                near_load_b = stg_q[k].is_load && (k <= LOAD_LAT);
            end
        end
        lu_stall = fd_live & (near_load_a | near_load_b);
    end

    always_comb begin
        pc_sel_c   = PC_SEL_PLUS4;
        stall_c    = 1'b0;
        kill_cnt_d = kill_cnt_q;
        if (!mem_ready) begin
            stall_c  = 1'b1;
            pc_sel_c = PC_SEL_HOLD;
        end else if (redirect) begin
            pc_sel_c   = PC_SEL_ALU;
            kill_cnt_d = KW'(FLUSH_DEPTH - 1);
        end else if (killing) begin
            kill_cnt_d = kill_cnt_q - KW'(1);
        end else if (lu_stall) begin
            stall_c  = 1'b1;
            pc_sel_c = PC_SEL_HOLD;
        end else if (fd_live && dec_is_jal) begin
            pc_sel_c = PC_SEL_JAL;
        end
    end

    always_comb begin
        fd_meta           = '0;
        fd_meta.valid     = 1'b1;
        fd_meta.rd        = dec_rd;
        fd_meta.wr_en     = dec_wr_en;
        fd_meta.is_load   = dec_is_load;
        fd_meta.is_jalr   = dec_is_jalr;
        fd_meta.is_branch = dec_is_branch;

        stg_d = stg_q;
        if (mem_ready) begin
            for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
                stg_d[k] = stg_q[k-1];
            end
            stg_d[1] = (fd_live && !lu_stall) ? fd_meta : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
                stg_q[k] <= '0;
            end
            kill_cnt_q <= '0;
        end else begin
            stg_q      <= stg_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    always_comb begin
        pc_sel    = rst ? PC_SEL_PLUS4 : pc_sel_c;
        is_j_or_b = ~rst & stg_q[1].valid & (stg_q[1].is_jalr | stg_q[1].is_branch);
        fwd_a_sel = rst ? '0 : sel_a;
        fwd_b_sel = rst ? '0 : sel_b;
        stall     = ~rst & stall_c;
        flush_fd  = ~rst & flush_c;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (NUM_STAGES=2, LOAD_LAT=1,
// FLUSH_DEPTH=2). Inputs change 1 ns after the rising edge, outputs are
// checked on the falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_fd;
    logic        fd_valid;
    logic        br_taken_x;
    logic        mem_ready;
    logic [1:0]  pc_sel;
    logic        is_j_or_b;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic        flush_fd;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    hazard_ctrl #(
        .NUM_STAGES  (2),
        .REG_AW      (5),
        .LOAD_LAT    (1),
        .FLUSH_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_fd    (inst_fd),
        .fd_valid   (fd_valid),
        .br_taken_x (br_taken_x),
        .mem_ready  (mem_ready),
        .pc_sel     (pc_sel),
        .is_j_or_b  (is_j_or_b),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .flush_fd   (flush_fd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_add(input int unsigned rd, input int unsigned rs1,
                                          input int unsigned rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] i_type(input logic [6:0] op, input int unsigned rd,
                                           input int unsigned rs1, input int unsigned imm,
                                           input int unsigned f3);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] beq(input int unsigned rs1, input int unsigned rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'h63};
    endfunction

    function automatic logic [31:0] jal(input int unsigned rd);
        return {20'b0, 5'(rd), 7'h6F};
    endfunction

    task automatic set_in(input logic [31:0] i, input logic v, input logic t, input logic r);
        inst_fd    = i;
        fd_valid   = v;
        br_taken_x = t;
        mem_ready  = r;
        #4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a JAL in FD: outputs must stay at their forced values.
        rst = 1'b1;
        inst_fd = '0; fd_valid = 1'b0; br_taken_x = 1'b0; mem_ready = 1'b1;
        step();
        set_in(jal(1), 1'b1, 1'b0, 1'b1);
        check("rst_pc_sel", pc_sel, 2);
        check("rst_stall", stall, 0);
        check("rst_flush", flush_fd, 0);
        check("rst_fwd_a", fwd_a_sel, 0);
        check("rst_fwd_b", fwd_b_sel, 0);
        check("rst_jb", is_j_or_b, 0);
        step();
        rst = 1'b0;

        // Back-to-back ALU dependency, then one NOP of distance.
        set_in(r_add(5, 1, 2), 1'b1, 1'b0, 1'b1);
        check("add5_fwd_a", fwd_a_sel, 0);
        check("add5_pc", pc_sel, 2);
        step();
        set_in(r_add(6, 5, 5), 1'b1, 1'b0, 1'b1);
        check("b2b_fwd_a", fwd_a_sel, 1);
        check("b2b_fwd_b", fwd_b_sel, 1);
        check("b2b_stall", stall, 0);
        step();
        set_in(NOP, 1'b1, 1'b0, 1'b1);
        step();
        set_in(r_add(9, 6, 6), 1'b1, 1'b0, 1'b1);
        check("dist2_fwd_a", fwd_a_sel, 2);
        check("dist2_fwd_b", fwd_b_sel, 2);
        step();

        // Load-use: one stall cycle, then forward from stage 2.
        set_in(i_type(7'h03, 7, 1, 0, 2), 1'b1, 1'b0, 1'b1);
        check("lw_fwd_a", fwd_a_sel, 0);
        check("lw_stall", stall, 0);
        step();
        set_in(r_add(8, 7, 0), 1'b1, 1'b0, 1'b1);
        check("lu_fwd_a", fwd_a_sel, 1);
        check("lu_fwd_b_x0", fwd_b_sel, 0);
        check("lu_stall", stall, 1);
        check("lu_pc", pc_sel, 3);
        check("lu_flush", flush_fd, 0);
        step();
        set_in(r_add(8, 7, 0), 1'b1, 1'b0, 1'b1);
        check("lu2_fwd_a", fwd_a_sel, 2);
        check("lu2_stall", stall, 0);
        check("lu2_pc", pc_sel, 2);
        check("lu2_jb", is_j_or_b, 0);
        step();

        // Taken branch with FLUSH_DEPTH=2.
        set_in(beq(8, 8), 1'b1, 1'b0, 1'b1);
        check("beq_fwd_a", fwd_a_sel, 1);
        check("beq_fwd_b", fwd_b_sel, 1);
        check("beq_pc", pc_sel, 2);
        step();
        set_in(r_add(10, 1, 1), 1'b1, 1'b1, 1'b1);
        check("tk_pc", pc_sel, 1);
        check("tk_flush", flush_fd, 1);
        check("tk_stall", stall, 0);
        check("tk_jb", is_j_or_b, 1);
        step();
        set_in(r_add(11, 1, 1), 1'b1, 1'b0, 1'b1);
        check("kill_flush", flush_fd, 1);
        check("kill_pc", pc_sel, 2);
        check("kill_jb", is_j_or_b, 0);
        step();
        set_in(NOP, 1'b1, 1'b0, 1'b1);
        check("post_kill_flush", flush_fd, 0);
        check("post_kill_pc", pc_sel, 2);
        step();

        // Not-taken branch.
        set_in(beq(1, 2), 1'b1, 1'b0, 1'b1);
        check("nt_issue_pc", pc_sel, 2);
        step();
        set_in(NOP, 1'b1, 1'b0, 1'b1);
        check("nt_pc", pc_sel, 2);
        check("nt_jb", is_j_or_b, 1);
        check("nt_flush", flush_fd, 0);
        step();

        // JAL with idle X, then JAL in FD behind a JALR in X.
        set_in(jal(1), 1'b1, 1'b0, 1'b1);
        check("jal_pc", pc_sel, 0);
        step();
        set_in(i_type(7'h67, 4, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        check("jalr_fwd_a", fwd_a_sel, 1);
        check("jalr_pc", pc_sel, 2);
        step();
        set_in(jal(3), 1'b1, 1'b0, 1'b1);
        check("jr_pc", pc_sel, 1);
        check("jr_flush", flush_fd, 1);
        check("jr_jb", is_j_or_b, 1);
        step();

        // Reset while a kill is pending (and the pipe is frozen).
        rst = 1'b1;
        set_in(NOP, 1'b1, 1'b0, 1'b0);
        check("rstk_flush", flush_fd, 0);
        check("rstk_stall", stall, 0);
        check("rstk_pc", pc_sel, 2);
        step();
        rst = 1'b0;
        set_in(r_add(12, 4, 4), 1'b1, 1'b0, 1'b1);
        check("postrst_flush", flush_fd, 0);
        check("postrst_fwd_a", fwd_a_sel, 0);
        check("postrst_fwd_b", fwd_b_sel, 0);
        check("postrst_pc", pc_sel, 2);
        step();

        // x0 never forwards; memory freeze holds all state.
        set_in(i_type(7'h13, 0, 0, 1, 0), 1'b1, 1'b0, 1'b1);
        step();
        for (int unsigned c = 0; c < 3; c++) begin
            set_in(r_add(13, 0, 12), 1'b1, 1'b0, 1'b0);
            check("frz_fwd_a", fwd_a_sel, 0);
            check("frz_fwd_b", fwd_b_sel, 2);
            check("frz_stall", stall, 1);
            check("frz_pc", pc_sel, 3);
            check("frz_flush", flush_fd, 0);
            step();
        end
        set_in(r_add(13, 0, 12), 1'b1, 1'b0, 1'b1);
        check("rel_fwd_a", fwd_a_sel, 0);
        check("rel_fwd_b", fwd_b_sel, 2);
        check("rel_stall", stall, 0);
        check("rel_pc", pc_sel, 2);
        step();
        set_in(r_add(14, 13, 12), 1'b1, 1'b0, 1'b1);
        check("after_fwd_a", fwd_a_sel, 1);
        check("after_fwd_b", fwd_b_sel, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
